// File: rtl/redmule_tcdm_arbiter_if.sv
// Bus bundle between the RedMulE wide streamer, the core data port and the MP-lane TCDM bank.
// The arbiter takes the slave view; the surrounding system (or bench) takes the master view.
interface redmule_tcdm_arbiter_if #(
   parameter int unsigned MP = 8
);
   logic              hwpe_req_i;
   logic              hwpe_gnt_o;
   logic [31:0]       hwpe_add_i;
   logic              hwpe_wen_i;
   logic [4*MP-1:0]   hwpe_be_i;
   logic [32*MP-1:0]  hwpe_data_i;
   logic              hwpe_r_valid_o;
   logic [32*MP-1:0]  hwpe_r_data_o;

   logic              core_req_i;
   logic              core_gnt_o;
   logic [31:0]       core_add_i;
   logic              core_wen_i;
   logic [3:0]        core_be_i;
   logic [31:0]       core_data_i;
   logic              core_r_valid_o;
   logic [31:0]       core_r_data_o;

   logic [MP-1:0]     mem_req_o;
   logic [32*MP-1:0]  mem_add_o;
   logic [MP-1:0]     mem_wen_o;
   logic [4*MP-1:0]   mem_be_o;
   logic [32*MP-1:0]  mem_data_o;
   logic [MP-1:0]     mem_gnt_i;
   logic [MP-1:0]     mem_r_valid_i;
   logic [32*MP-1:0]  mem_r_data_i;

   modport slave (
      input  hwpe_req_i, hwpe_add_i, hwpe_wen_i, hwpe_be_i, hwpe_data_i,
      output hwpe_gnt_o, hwpe_r_valid_o, hwpe_r_data_o,
      input  core_req_i, core_add_i, core_wen_i, core_be_i, core_data_i,
      output core_gnt_o, core_r_valid_o, core_r_data_o,
      output mem_req_o, mem_add_o, mem_wen_o, mem_be_o, mem_data_o,
      input  mem_gnt_i, mem_r_valid_i, mem_r_data_i
   );

   modport master (
      output hwpe_req_i, hwpe_add_i, hwpe_wen_i, hwpe_be_i, hwpe_data_i,
      input  hwpe_gnt_o, hwpe_r_valid_o, hwpe_r_data_o,
      output core_req_i, core_add_i, core_wen_i, core_be_i, core_data_i,
      input  core_gnt_o, core_r_valid_o, core_r_data_o,
      input  mem_req_o, mem_add_o, mem_wen_o, mem_be_o, mem_data_o,
      output mem_gnt_i, mem_r_valid_i, mem_r_data_i
   );
endinterface

// File: rtl/redmule_tcdm_arbiter.sv
// HWPE-priority TCDM arbiter with core starvation boost and in-order owner-tracked responses.
// Optional performance counters are enabled by defining REDMULE_TCDM_ARB_PERF_CNT_EN.
//
// state     | meaning
// PRIO_HWPE | wide streamer wins ties; counting consecutive core losses
// PRIO_CORE | core boosted after STARVE_LIMIT losses until it handshakes or drops req
module redmule_tcdm_arbiter #(
   parameter int unsigned MP           = 8,
   parameter int unsigned MAX_OUT      = 2,
   parameter int unsigned STARVE_LIMIT = 16
) (
   input  logic clk_i,
   input  logic rst_i,
`ifdef REDMULE_TCDM_ARB_PERF_CNT_EN
   input  logic        perf_clr_i,
   output logic [31:0] perf_hwpe_gnt_o,
   output logic [31:0] perf_core_gnt_o,
   output logic [31:0] perf_core_stall_o,
`endif
   redmule_tcdm_arbiter_if.slave bus
);
   localparam int unsigned LW = $clog2(MP);
   localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int unsigned CW = $clog2(MAX_OUT + 1);
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {PRIO_HWPE, PRIO_CORE} prio_e;

   prio_e          state_q, state_d;
   logic [SW-1:0]  starve_q, starve_d;
   logic [LW-1:0]  core_lane;
   logic           fifo_full, hwpe_win, core_win, hwpe_hs, core_hs, push, pop;
   logic           hwpe_rv, core_rv, head_owner;
   logic [LW-1:0]  head_lane;
   logic [CW-1:0]  cnt_q;
   logic [PW-1:0]  wr_q, rd_q;
   logic           owner_q [MAX_OUT];
   logic [LW-1:0]  lane_q  [MAX_OUT];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
   endfunction

   assign core_lane = bus.core_add_i[2 +: LW];
   // A same-cycle pop never unblocks a full FIFO, so only the registered count is used.
   assign fifo_full = (cnt_q == CW'(MAX_OUT));

   always_comb begin
      hwpe_win = 1'b0;
      core_win = 1'b0;
      if (!rst_i && !fifo_full) begin
         if (state_q == PRIO_HWPE) begin
            hwpe_win = bus.hwpe_req_i;
            core_win = !bus.hwpe_req_i && bus.core_req_i;
         end else begin
            core_win = bus.core_req_i;
            hwpe_win = !bus.core_req_i && bus.hwpe_req_i;
         end
      end
   end

   assign hwpe_hs        = hwpe_win & (&bus.mem_gnt_i);
   assign core_hs        = core_win & bus.mem_gnt_i[core_lane];
   assign bus.hwpe_gnt_o = hwpe_hs;
   assign bus.core_gnt_o = core_hs;
   assign push           = hwpe_hs | core_hs;

   always_comb begin
      bus.mem_req_o  = '0;
      bus.mem_add_o  = '0;
      bus.mem_wen_o  = '0;
      bus.mem_be_o   = '0;
      bus.mem_data_o = '0;
      for (int ii = 0; ii < MP; ii++) begin
         if (hwpe_win) begin
            bus.mem_req_o[ii]           = 1'b1;
            bus.mem_add_o[32*ii +: 32]  = bus.hwpe_add_i + 32'(4 * ii);
            bus.mem_wen_o[ii]           = bus.hwpe_wen_i;
            bus.mem_be_o[4*ii +: 4]     = bus.hwpe_be_i[4*ii +: 4];
            bus.mem_data_o[32*ii +: 32] = bus.hwpe_data_i[32*ii +: 32];
         end else if (core_win && (core_lane == LW'(ii))) begin
            bus.mem_req_o[ii]           = 1'b1;
            bus.mem_add_o[32*ii +: 32]  = bus.core_add_i;
            bus.mem_wen_o[ii]           = bus.core_wen_i;
            bus.mem_be_o[4*ii +: 4]     = bus.core_be_i;
            bus.mem_data_o[32*ii +: 32] = bus.core_data_i;
         end
      end
   end

   // Responses with no outstanding owner are dropped.
   assign head_owner         = owner_q[rd_q];
   assign head_lane          = lane_q[rd_q];
   assign hwpe_rv            = (cnt_q != '0) && !head_owner && (&bus.mem_r_valid_i);
   assign core_rv            = (cnt_q != '0) && head_owner && bus.mem_r_valid_i[head_lane];
   assign pop                = hwpe_rv | core_rv;
   assign bus.hwpe_r_valid_o = hwpe_rv;
   assign bus.core_r_valid_o = core_rv;
   assign bus.hwpe_r_data_o  = hwpe_rv ? bus.mem_r_data_i : '0;
   assign bus.core_r_data_o  = core_rv ? bus.mem_r_data_i[32*head_lane +: 32] : 32'h0;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         for (int i = 0; i < MAX_OUT; i++) begin
            owner_q[i] <= 1'b0;
            lane_q[i]  <= '0;
         end
      end else begin
         if (push) begin
            owner_q[wr_q] <= core_hs;
            lane_q[wr_q]  <= core_lane;
            wr_q          <= ptr_inc(wr_q);
         end
         if (pop) rd_q <= ptr_inc(rd_q);
         if (push && !pop)      cnt_q <= cnt_q + CW'(1);
         else if (pop && !push) cnt_q <= cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= PRIO_HWPE;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      if (state_q == PRIO_HWPE) begin
         if (!bus.core_req_i || core_hs) begin
            starve_d = '0;
         end else if (starve_q + SW'(1) == SW'(STARVE_LIMIT)) begin
            state_d  = PRIO_CORE;
            starve_d = SW'(STARVE_LIMIT);
         end else begin
            starve_d = starve_q + SW'(1);
         end
      end else if (!bus.core_req_i || core_hs) begin
         state_d  = PRIO_HWPE;
         starve_d = '0;
      end
   end

`ifdef REDMULE_TCDM_ARB_PERF_CNT_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         perf_hwpe_gnt_o   <= '0;
         perf_core_gnt_o   <= '0;
         perf_core_stall_o <= '0;
      end else if (perf_clr_i) begin
         perf_hwpe_gnt_o   <= '0;
         perf_core_gnt_o   <= '0;
         perf_core_stall_o <= '0;
      end else begin
         if (hwpe_hs && (perf_hwpe_gnt_o != '1)) perf_hwpe_gnt_o <= perf_hwpe_gnt_o + 32'd1;
         if (core_hs && (perf_core_gnt_o != '1)) perf_core_gnt_o <= perf_core_gnt_o + 32'd1;
         if (bus.core_req_i && !core_hs && (perf_core_stall_o != '1))
            perf_core_stall_o <= perf_core_stall_o + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_redmule_tcdm_arbiter.sv
// Randomized bench for redmule_tcdm_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_redmule_tcdm_arbiter;
   localparam int MP = 8;
   localparam int MAX_OUT = 2;
   localparam int SL = 16;
   localparam int W = 32 * MP;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   redmule_tcdm_arbiter_if #(.MP(MP)) bus ();

`ifdef REDMULE_TCDM_ARB_PERF_CNT_EN
   logic        perf_clr_i;
   logic [31:0] perf_hwpe_gnt_o, perf_core_gnt_o, perf_core_stall_o;
`endif

   redmule_tcdm_arbiter #(.MP(MP), .MAX_OUT(MAX_OUT), .STARVE_LIMIT(SL)) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
`ifdef REDMULE_TCDM_ARB_PERF_CNT_EN
      .perf_clr_i(perf_clr_i),
      .perf_hwpe_gnt_o(perf_hwpe_gnt_o),
      .perf_core_gnt_o(perf_core_gnt_o),
      .perf_core_stall_o(perf_core_stall_o),
`endif
      .bus(bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference state: outstanding owners (0 = HWPE, 16+lane = core), priority boost.
   int          own_q[$];
   bit          boosted = 1'b0;
   int          lost = 0;
   logic [31:0] m_ph = '0, m_pc = '0, m_ps = '0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk_i) begin : compare
      int lane, hl;
      bit hw_w, co_w, full, e_hg, e_cg, e_hrv, e_crv;
      logic [MP-1:0] e_req, e_wen;
      logic [W-1:0] e_add, e_data;
      logic [4*MP-1:0] e_be;
      if (rst_i) begin
         own_q.delete();
         boosted = 1'b0;
         lost = 0;
         m_ph = '0; m_pc = '0; m_ps = '0;
         check("rst_hwpe_gnt", W'(bus.hwpe_gnt_o), '0);
         check("rst_core_gnt", W'(bus.core_gnt_o), '0);
         check("rst_hwpe_rvalid", W'(bus.hwpe_r_valid_o), '0);
         check("rst_core_rvalid", W'(bus.core_r_valid_o), '0);
         check("rst_mem_req", W'(bus.mem_req_o), '0);
      end else begin
         lane = int'((bus.core_add_i >> 2) % MP);
         full = (own_q.size() == MAX_OUT);
         hw_w = 1'b0; co_w = 1'b0;
         if (!full) begin
            if (boosted) begin
               co_w = bus.core_req_i;
               hw_w = bus.hwpe_req_i && !bus.core_req_i;
            end else begin
               hw_w = bus.hwpe_req_i;
               co_w = bus.core_req_i && !bus.hwpe_req_i;
            end
         end
         e_hg = hw_w && (bus.mem_gnt_i == {MP{1'b1}});
         e_cg = co_w && bus.mem_gnt_i[lane];
         e_req = '0; e_wen = '0; e_add = '0; e_data = '0; e_be = '0;
         for (int i = 0; i < MP; i++) begin
            if (hw_w) begin
               e_req[i] = 1'b1;
               e_add[32*i +: 32] = bus.hwpe_add_i + 4 * i;
               e_wen[i] = bus.hwpe_wen_i;
               e_be[4*i +: 4] = bus.hwpe_be_i[4*i +: 4];
               e_data[32*i +: 32] = bus.hwpe_data_i[32*i +: 32];
            end else if (co_w && i == lane) begin
               e_req[i] = 1'b1;
               e_add[32*i +: 32] = bus.core_add_i;
               e_wen[i] = bus.core_wen_i;
               e_be[4*i +: 4] = bus.core_be_i;
               e_data[32*i +: 32] = bus.core_data_i;
            end
         end
         e_hrv = 1'b0; e_crv = 1'b0; hl = 0;
         if (own_q.size() > 0) begin
            if (own_q[0] < 16) e_hrv = (bus.mem_r_valid_i == {MP{1'b1}});
            else begin
               hl = own_q[0] - 16;
               e_crv = bus.mem_r_valid_i[hl];
            end
         end
         check("hwpe_gnt", W'(bus.hwpe_gnt_o), W'(e_hg));
         check("core_gnt", W'(bus.core_gnt_o), W'(e_cg));
         check("mem_req", W'(bus.mem_req_o), W'(e_req));
         check("mem_add", bus.mem_add_o, e_add);
         check("mem_wen", W'(bus.mem_wen_o), W'(e_wen));
         check("mem_be", W'(bus.mem_be_o), W'(e_be));
         check("mem_data", bus.mem_data_o, e_data);
         check("hwpe_r_valid", W'(bus.hwpe_r_valid_o), W'(e_hrv));
         check("hwpe_r_data", bus.hwpe_r_data_o, e_hrv ? bus.mem_r_data_i : '0);
         check("core_r_valid", W'(bus.core_r_valid_o), W'(e_crv));
         check("core_r_data", W'(bus.core_r_data_o), e_crv ? W'(bus.mem_r_data_i[32*hl +: 32]) : '0);
`ifdef REDMULE_TCDM_ARB_PERF_CNT_EN
         check("perf_hwpe_gnt", W'(perf_hwpe_gnt_o), W'(m_ph));
         check("perf_core_gnt", W'(perf_core_gnt_o), W'(m_pc));
         check("perf_core_stall", W'(perf_core_stall_o), W'(m_ps));
         if (perf_clr_i) begin
            m_ph = '0; m_pc = '0; m_ps = '0;
         end else begin
            if (e_hg && m_ph != '1) m_ph++;
            if (e_cg && m_pc != '1) m_pc++;
            if (bus.core_req_i && !e_cg && m_ps != '1) m_ps++;
         end
`endif
         if (e_hrv || e_crv) void'(own_q.pop_front());
         if (e_hg) own_q.push_back(0);
         if (e_cg) own_q.push_back(16 + lane);
         if (!bus.core_req_i || e_cg) begin
            lost = 0;
            boosted = 1'b0;
         end else if (!boosted) begin
            lost++;
            if (lost == SL) boosted = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      bus.hwpe_req_i = 1'b0; bus.hwpe_add_i = '0; bus.hwpe_wen_i = 1'b1;
      bus.hwpe_be_i = '1; bus.hwpe_data_i = '0;
      bus.core_req_i = 1'b0; bus.core_add_i = '0; bus.core_wen_i = 1'b1;
      bus.core_be_i = 4'hF; bus.core_data_i = '0;
      bus.mem_gnt_i = '1; bus.mem_r_valid_i = '0; bus.mem_r_data_i = '0;
`ifdef REDMULE_TCDM_ARB_PERF_CNT_EN
      perf_clr_i = 1'b0;
`endif
   endtask

   // Memory side: answer the oldest outstanding transaction with probability pct.
   task automatic respond(input int pct);
      bus.mem_r_valid_i = '0;
      for (int i = 0; i < MP; i++) bus.mem_r_data_i[32*i +: 32] = $urandom;
      if (own_q.size() > 0) begin
         if ($urandom_range(0, 99) < pct) begin
            if (own_q[0] < 16) bus.mem_r_valid_i = '1;
            else begin
               bus.mem_r_valid_i = MP'($urandom);
               bus.mem_r_valid_i[own_q[0] - 16] = 1'b1;
            end
         end
      end else if ($urandom_range(0, 7) == 0) begin
         bus.mem_r_valid_i = MP'($urandom);
      end
   endtask

   initial begin
      int bias;
      idle();
      bus.hwpe_req_i = 1'b1;
      bus.core_req_i = 1'b1;
      #2;
      check("reset_gnts", W'({bus.hwpe_gnt_o, bus.core_gnt_o}), '0);
      check("reset_mem_req", W'(bus.mem_req_o), '0);
`ifdef REDMULE_TCDM_ARB_PERF_CNT_EN
      check("reset_perf", W'({perf_hwpe_gnt_o, perf_core_gnt_o, perf_core_stall_o}), '0);
`endif
      tick(); tick();
      rst_i = 1'b0;
      idle();

      // Core-only read, lane 5.
      tick(); idle();
      bus.core_req_i = 1'b1; bus.core_add_i = 32'h1C01_0014;
      #3;
      check("d_core_mem_req", W'(bus.mem_req_o), W'(8'b0010_0000));
      check("d_core_gnt", W'(bus.core_gnt_o), W'(1'b1));
      check("d_core_lane5_add", W'(bus.mem_add_o[5*32 +: 32]), W'(32'h1C01_0014));
      tick(); idle();
      bus.mem_r_valid_i = 8'b0010_0000;
      bus.mem_r_data_i = '1;
      bus.mem_r_data_i[5*32 +: 32] = 32'hCAFE_0005;
      #3;
      check("d_core_rvalid", W'(bus.core_r_valid_o), W'(1'b1));
      check("d_core_rdata", W'(bus.core_r_data_o), W'(32'hCAFE_0005));

      // Both request: HWPE wins.
      tick(); idle();
      bus.hwpe_req_i = 1'b1; bus.hwpe_add_i = 32'h1000_0100;
      bus.core_req_i = 1'b1; bus.core_add_i = 32'h0000_001C;
      #3;
      check("d_both_gnts", W'({bus.hwpe_gnt_o, bus.core_gnt_o}), W'(2'b10));
      check("d_both_lane3_add", W'(bus.mem_add_o[3*32 +: 32]), W'(32'h1000_010C));
      tick(); idle(); respond(100);
      #3;
      check("d_both_hwpe_rvalid", W'(bus.hwpe_r_valid_o), W'(1'b1));

      // Starvation: core granted on cycle 17, HWPE back on cycle 18.
      tick(); idle();
      for (int k = 1; k <= 18; k++) begin
         tick(); idle();
         bus.hwpe_req_i = 1'b1; bus.core_req_i = 1'b1; bus.core_add_i = 32'h0000_0004;
         respond(100);
         #3;
         if (k == 16) check("d_starve_c16", W'({bus.hwpe_gnt_o, bus.core_gnt_o}), W'(2'b10));
         if (k == 17) check("d_starve_c17", W'({bus.hwpe_gnt_o, bus.core_gnt_o}), W'(2'b01));
         if (k == 18) check("d_starve_c18", W'({bus.hwpe_gnt_o, bus.core_gnt_o}), W'(2'b10));
      end
      for (int k = 0; k < 3; k++) begin tick(); idle(); respond(100); end

      // Partial lane grant blocks the wide request.
      tick(); idle();
      bus.hwpe_req_i = 1'b1; bus.mem_gnt_i = 8'hFE;
      #3;
      check("d_fe_hwpe_gnt", W'(bus.hwpe_gnt_o), W'(1'b0));
      tick();
      bus.mem_gnt_i = 8'hFF;
      #3;
      check("d_ff_hwpe_gnt", W'(bus.hwpe_gnt_o), W'(1'b1));
      tick(); idle(); bus.mem_r_valid_i = '1;
      #3;
      check("d_ff_rvalid", W'(bus.hwpe_r_valid_o), W'(1'b1));
      tick(); idle(); bus.mem_r_valid_i = '1;
      #3;
      check("d_ff_stray_drop", W'(bus.hwpe_r_valid_o), W'(1'b0));

      // Withheld responses fill the owner FIFO; pop does not unblock.
      tick(); idle(); bus.hwpe_req_i = 1'b1;
      #3;
      check("d_full_h_gnt", W'(bus.hwpe_gnt_o), W'(1'b1));
      tick(); idle(); bus.core_req_i = 1'b1; bus.core_add_i = 32'h0000_0008;
      #3;
      check("d_full_c_gnt", W'(bus.core_gnt_o), W'(1'b1));
      tick(); idle(); bus.hwpe_req_i = 1'b1; bus.core_req_i = 1'b1;
      #3;
      check("d_full_mem_req", W'(bus.mem_req_o), '0);
      tick(); idle(); bus.hwpe_req_i = 1'b1; bus.mem_r_valid_i = '1;
      #3;
      check("d_full_pop_hwpe", W'({bus.hwpe_r_valid_o, bus.core_r_valid_o, bus.hwpe_gnt_o}), W'(3'b100));
      tick(); idle(); bus.mem_r_valid_i = 8'b0000_0100;
      bus.mem_r_data_i[2*32 +: 32] = 32'hBEEF_0002;
      #3;
      check("d_full_pop_core", W'({bus.core_r_valid_o, bus.core_r_data_o}), W'({1'b1, 32'hBEEF_0002}));

      // Reset with one outstanding; later stray response dropped.
      tick(); idle(); bus.hwpe_req_i = 1'b1;
      #3;
      check("d_rst_pre_gnt", W'(bus.hwpe_gnt_o), W'(1'b1));
      tick(); idle();
      bus.hwpe_req_i = 1'b1; bus.core_req_i = 1'b1; bus.mem_r_valid_i = '1;
      rst_i = 1'b1;
      #3;
      check("d_rst_outs", W'({bus.hwpe_gnt_o, bus.core_gnt_o, bus.hwpe_r_valid_o, bus.core_r_valid_o}), '0);
`ifdef REDMULE_TCDM_ARB_PERF_CNT_EN
      check("d_rst_perf", W'({perf_hwpe_gnt_o, perf_core_gnt_o, perf_core_stall_o}), '0);
`endif
      tick(); rst_i = 1'b0; idle(); bus.mem_r_valid_i = '1;
      #3;
      check("d_rst_stray", W'({bus.hwpe_r_valid_o, bus.core_r_valid_o}), '0);

      // Random traffic against the reference model.
      for (int n = 0; n < 4000; n++) begin
         tick();
         bias = ((n / 200) % 2 == 1) ? 95 : 50;
         bus.hwpe_req_i = ($urandom_range(0, 99) < bias);
         bus.hwpe_add_i = $urandom & ~32'h3;
         bus.hwpe_wen_i = 1'($urandom);
         bus.hwpe_be_i = $urandom;
         for (int i = 0; i < MP; i++) bus.hwpe_data_i[32*i +: 32] = $urandom;
         bus.core_req_i = ($urandom_range(0, 99) < 70);
         bus.core_add_i = $urandom;
         bus.core_wen_i = 1'($urandom);
         bus.core_be_i = 4'($urandom);
         bus.core_data_i = $urandom;
         bus.mem_gnt_i = ($urandom_range(0, 3) != 0) ? '1 : MP'($urandom);
`ifdef REDMULE_TCDM_ARB_PERF_CNT_EN
         perf_clr_i = ($urandom_range(0, 63) == 0);
`endif
         respond(60);
      end
      tick(); idle();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
